// File: rtl/pipo_load_arbiter.sv
//------------------------------------------------------------------------------
// Module      : pipo_load_arbiter
// Description : Round-robin arbiter sharing one PIPO register among N requesters
//               through an IDLE/LOAD/HOLD sequence. Optional even-parity output
//               q_par is enabled by defining PIPO_ARB_PARITY_EN.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipo_load_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   d_in,
    input  logic                 clr,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
`ifdef PIPO_ARB_PARITY_EN
    ,
    output logic                 q_par
`endif
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_W = (IW+1)'(N);
    localparam logic [3:0] HOLD_INIT = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    offset;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    ptr_inc;
    logic [IW:0]      wsum;
    logic [3:0]       hold_cnt;
    logic [N-1:0]     rot;
    logic             found;
    logic             req_sel;
    logic [WIDTH-1:0] sel_data;

    // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                offset = IW'(k);
                found  = 1'b1;
            end
        end
    end

    assign wsum    = {1'b0, ptr} + {1'b0, offset};
    assign winner  = (wsum >= N_W) ? IW'(wsum - N_W) : IW'(wsum);
    assign ptr_inc = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        sel_data = '0;
        req_sel  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_data = d_in[i*WIDTH +: WIDTH];
                req_sel  = req[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = (|req) ? S_LOAD : S_IDLE;
            S_LOAD: state_nxt = (req_sel && (HOLD_CYC > 0)) ? S_HOLD : S_IDLE;
            S_HOLD: state_nxt = (hold_cnt == 4'd0) ? S_IDLE : S_HOLD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Datapath; clr leaves ptr and sel untouched so fairness survives a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= '0;
            gnt      <= '0;
            ptr      <= '0;
            sel      <= '0;
            hold_cnt <= '0;
`ifdef PIPO_ARB_PARITY_EN
            q_par    <= 1'b0;
`endif
        end else if (clr) begin
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= '0;
            gnt      <= '0;
            hold_cnt <= '0;
`ifdef PIPO_ARB_PARITY_EN
            q_par    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        sel <= winner;
                        gnt <= {{(N-1){1'b0}}, 1'b1} << winner;
                    end
                end
                S_LOAD: begin
                    gnt <= '0;
                    if (req_sel) begin
                        q        <= sel_data;
                        q_valid  <= 1'b1;
                        owner    <= sel;
                        ptr      <= ptr_inc;
                        hold_cnt <= HOLD_INIT;
`ifdef PIPO_ARB_PARITY_EN
                        q_par    <= ^sel_data;
`endif
                    end
                end
                S_HOLD: begin
                    if (hold_cnt != 4'd0) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_pipo_load_arbiter
// Description : Directed and randomized bench for pipo_load_arbiter with a
//               cycle-level reference model (PIPO_ARB_PARITY_EN optional).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipo_load_arbiter;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int HOLD = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr   = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] d_in  = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [1:0]     owner;
    logic           busy;
`ifdef PIPO_ARB_PARITY_EN
    logic           q_par;
`endif

    pipo_load_arbiter #(.N(N), .WIDTH(W), .HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d_in    (d_in),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .busy    (busy)
`ifdef PIPO_ARB_PARITY_EN
        ,
        .q_par   (q_par)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: absolute edge count plus the edge at which the
    // arbiter may next sample requests.
    logic [W-1:0] m_q     = '0;
    bit           m_valid = 1'b0;
    bit           m_par   = 1'b0;
    bit           m_pend  = 1'b0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    int           m_sel   = 0;
    int           m_idle  = 0;
    int           e       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_valid = 0; m_par = 0; m_pend = 0;
        m_owner = 0; m_ptr = 0; m_sel = 0; m_idle = e;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic c);
        e++;
        if (c) begin
            m_q = '0; m_valid = 0; m_par = 0; m_owner = 0; m_pend = 0; m_idle = e;
        end else if (m_pend) begin
            m_pend = 0;
            if (r[m_sel]) begin
                m_q = d[m_sel*W +: W]; m_valid = 1; m_owner = m_sel; m_par = ^m_q;
                m_ptr = (m_sel + 1) % N;
                m_idle = e + HOLD;
            end else begin
                m_idle = e;
            end
        end else if (e > m_idle && r != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!m_pend && r[(m_ptr + k) % N]) begin
                    m_sel = (m_ptr + k) % N;
                    m_pend = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt", 32'(gnt), m_pend ? (32'd1 << m_sel) : 32'd0);
        chk("q", 32'(q), 32'(m_q));
        chk("q_valid", 32'(q_valid), 32'(m_valid));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_pend || (e < m_idle)));
`ifdef PIPO_ARB_PARITY_EN
        chk("q_par", 32'(q_par), 32'(m_par));
`endif
    endtask

    // Drive one cycle of inputs, update model at the edge, check, end at negedge.
    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic c);
        req = r; d_in = d; clr = c;
        @(posedge clk);
        if (rst_n) model_edge(r, d, c);
        else       model_reset();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    int gcyc[$];
    int gown[$];

    initial begin
        @(negedge clk);

        // Reset with random activity on the inputs
        for (int i = 0; i < 2; i++) step(N'($urandom), (N*W)'($urandom), 1'b0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(q_valid), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;

        // Single load latency
        step(4'b0001, 16'h0009, 1'b0);
        chk("t2_gnt", 32'(gnt), 32'd1);
        step(4'b0001, 16'h0009, 1'b0);
        chk("t2_q", 32'(q), 32'h9);
        chk("t2_owner", 32'(owner), 32'd0);
        chk("t2_valid", 32'(q_valid), 32'd1);
        step(4'b0000, 16'h0009, 1'b0);
        chk("t2_busy_hold", 32'(busy), 32'd1);
        step(4'b0000, 16'h0009, 1'b0);
        chk("t2_busy_low", 32'(busy), 32'd0);

        // Round-robin with all requesters held
        rst_n = 1'b0;
        step(4'b0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 16'h4321, 1'b0);
            if (gnt != '0) begin
                gcyc.push_back(i);
                gown.push_back(oh_idx(gnt));
            end
        end
        chk("t3_ngrants", 32'(gown.size()), 32'd5);
        for (int j = 0; j < 5 && j < gown.size(); j++) begin
            chk("t3_owner", 32'(gown[j]), 32'(j % N));
            // One LOAD cycle, HOLD hold cycles and one IDLE cycle between grants
            chk("t3_spacing", 32'(gcyc[j]), 32'(j * (HOLD + 2)));
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 16'h0000, 1'b0);

        // Withdraw during LOAD
        step(4'b0100, 16'h0650, 1'b0);
        chk("t4_gnt2", 32'(gnt), 32'b0100);
        step(4'b0000, 16'h0650, 1'b0);
        chk("t4_q_kept", 32'(q), 32'h1);
        chk("t4_idle", 32'(busy), 32'd0);
        step(4'b0110, 16'h0650, 1'b0);
        chk("t4_gnt1", 32'(gnt), 32'b0010);
        step(4'b0110, 16'h0650, 1'b0);
        chk("t4_q", 32'(q), 32'h5);
        for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000, 1'b0);

        // clr collides with a LOAD
        step(4'b0100, 16'h0A00, 1'b0);
        chk("t5_gnt", 32'(gnt), 32'b0100);
        step(4'b0100, 16'h0A00, 1'b1);
        chk("t5_q", 32'(q), 32'h0);
        chk("t5_valid", 32'(q_valid), 32'd0);
        chk("t5_gnt0", 32'(gnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);

        // Async reset while holding
        step(4'b0001, 16'h000B, 1'b0);
        step(4'b0001, 16'h000B, 1'b0);
        chk("t6_q", 32'(q), 32'hB);
`ifdef PIPO_ARB_PARITY_EN
        chk("t6_par", 32'(q_par), 32'd1);
`endif
        step(4'b0000, 16'h000B, 1'b0);
        chk("t6_in_hold", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_q", 32'(q), 32'd0);
        chk("t6_async_valid", 32'(q_valid), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_gnt", 32'(gnt), 32'd0);
`ifdef PIPO_ARB_PARITY_EN
        chk("t6_async_par", 32'(q_par), 32'd0);
`endif
        step(4'b0000, 16'h0000, 1'b0);
        rst_n = 1'b1;

        // Randomized traffic with occasional clr
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0) ? N'($urandom) : req,
                 ($urandom_range(0, 1) == 0) ? (N*W)'($urandom) : d_in,
                 ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
